// File: rtl/prf_pkg.sv
// Shared physical register file sizing, used by rename, issue and the register file.
package prf_pkg;
   localparam int unsigned XLEN_DEF      = 32;
   localparam int unsigned NUM_PREGS_DEF = 64;
   localparam int unsigned NUM_RD_DEF    = 4;
   localparam int unsigned NUM_WR_DEF    = 2;
   localparam int unsigned NUM_ALLOC_DEF = 1;
   localparam int unsigned PW_DEF        = $clog2(NUM_PREGS_DEF);
endpackage

// File: rtl/prf_ready_table.sv
// Per-register ready bits: allocate clears, write-back sets, flush sets all.
module prf_ready_table
   import prf_pkg::*;
#(
   parameter int unsigned NUM_PREGS = NUM_PREGS_DEF,
   parameter int unsigned NUM_RD    = NUM_RD_DEF,
   parameter int unsigned NUM_WR    = NUM_WR_DEF,
   parameter int unsigned NUM_ALLOC = NUM_ALLOC_DEF,
   localparam int unsigned PW       = $clog2(NUM_PREGS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_WR-1:0]               wr_en,
   input  logic [NUM_WR-1:0][PW-1:0]       wr_idx,
   input  logic [NUM_ALLOC-1:0]            alloc_en,
   input  logic [NUM_ALLOC-1:0][PW-1:0]    alloc_idx,
   input  logic                            flush,
   input  logic [NUM_RD-1:0][PW-1:0]       rd_idx,
   output logic [NUM_RD-1:0]               rd_ready
);

   logic [NUM_PREGS-1:0] ready_q;
   logic [NUM_PREGS-1:0] ready_d;
   logic [NUM_RD-1:0]    wake;
   logic [NUM_RD-1:0]    alloc_hit;

   // Priority low to high: write sets, allocate clears, flush sets all; p0 pinned ready.
   always_comb begin
      ready_d = ready_q;
      for (int j = 0; j < int'(NUM_WR); j++) begin
         if (wr_en[j]) ready_d[wr_idx[j]] = 1'b1;
      end
      for (int k = 0; k < int'(NUM_ALLOC); k++) begin
         if (alloc_en[k]) ready_d[alloc_idx[k]] = 1'b0;
      end
      if (flush) ready_d = '1;
      ready_d[0] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_q <= '1;
      else        ready_q <= ready_d;
   end

   // Wakeup bypass is suppressed when the same register is being reallocated.
   always_comb begin
      rd_ready  = '1;
      wake      = '0;
      alloc_hit = '0;
      for (int i = 0; i < int'(NUM_RD); i++) begin
         for (int j = 0; j < int'(NUM_WR); j++) begin
            if (wr_en[j] && (wr_idx[j] == rd_idx[i])) wake[i] = 1'b1;
         end
         for (int k = 0; k < int'(NUM_ALLOC); k++) begin
            if (alloc_en[k] && (alloc_idx[k] == rd_idx[i])) alloc_hit[i] = 1'b1;
         end
         if (rst_n && (rd_idx[i] != '0)) begin
            rd_ready[i] = alloc_hit[i] ? ready_q[rd_idx[i]]
                                       : (ready_q[rd_idx[i]] | wake[i]);
         end
      end
   end

endmodule

// File: rtl/phys_regfile.sv
// Physical register file: data storage with write-through bypass plus ready tracking.
module phys_regfile
   import prf_pkg::*;
#(
   parameter int unsigned XLEN      = XLEN_DEF,
   parameter int unsigned NUM_PREGS = NUM_PREGS_DEF,
   parameter int unsigned NUM_RD    = NUM_RD_DEF,
   parameter int unsigned NUM_WR    = NUM_WR_DEF,
   parameter int unsigned NUM_ALLOC = NUM_ALLOC_DEF,
   localparam int unsigned PW       = $clog2(NUM_PREGS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_WR-1:0]               wr_en,
   input  logic [NUM_WR-1:0][PW-1:0]       wr_idx,
   input  logic [NUM_WR-1:0][XLEN-1:0]     wr_data,
   input  logic [NUM_RD-1:0][PW-1:0]       rd_idx,
   output logic [NUM_RD-1:0][XLEN-1:0]     rd_data,
   output logic [NUM_RD-1:0]               rd_ready,
   input  logic [NUM_ALLOC-1:0]            alloc_en,
   input  logic [NUM_ALLOC-1:0][PW-1:0]    alloc_idx,
   input  logic                            flush
);

   logic [XLEN-1:0] mem_q [NUM_PREGS];
   logic [XLEN-1:0] mem_d [NUM_PREGS];

   // Later write ports overwrite earlier ones; p0 is never written.
   always_comb begin
      mem_d = mem_q;
      for (int j = 0; j < int'(NUM_WR); j++) begin
         if (wr_en[j] && (wr_idx[j] != '0)) mem_d[wr_idx[j]] = wr_data[j];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem_q <= '{default: '0};
      else        mem_q <= mem_d;
   end

   // Same highest-port-wins ordering as storage, so bypass matches the next-cycle value.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < int'(NUM_RD); i++) begin
         if (rst_n && (rd_idx[i] != '0)) begin
            rd_data[i] = mem_q[rd_idx[i]];
            for (int j = 0; j < int'(NUM_WR); j++) begin
               if (wr_en[j] && (wr_idx[j] == rd_idx[i])) rd_data[i] = wr_data[j];
            end
         end
      end
   end

   prf_ready_table #(
      .NUM_PREGS (NUM_PREGS),
      .NUM_RD    (NUM_RD),
      .NUM_WR    (NUM_WR),
      .NUM_ALLOC (NUM_ALLOC)
   ) u_ready (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .alloc_en  (alloc_en),
      .alloc_idx (alloc_idx),
      .flush     (flush),
      .rd_idx    (rd_idx),
      .rd_ready  (rd_ready)
   );

endmodule

// File: tb/tb_phys_regfile.sv
// Self-checking bench for phys_regfile against an array-based reference model.
module tb_phys_regfile;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned NUM_PREGS = 64;
   localparam int unsigned NUM_RD    = 4;
   localparam int unsigned NUM_WR    = 2;
   localparam int unsigned NUM_ALLOC = 1;
   localparam int unsigned PW        = 6;

   logic                          clk;
   logic                          rst_n;
   logic [NUM_WR-1:0]             wr_en;
   logic [NUM_WR-1:0][PW-1:0]     wr_idx;
   logic [NUM_WR-1:0][XLEN-1:0]   wr_data;
   logic [NUM_RD-1:0][PW-1:0]     rd_idx;
   logic [NUM_RD-1:0][XLEN-1:0]   rd_data;
   logic [NUM_RD-1:0]             rd_ready;
   logic [NUM_ALLOC-1:0]          alloc_en;
   logic [NUM_ALLOC-1:0][PW-1:0]  alloc_idx;
   logic                          flush;

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] m_mem [NUM_PREGS];
   bit              m_rdy [NUM_PREGS];

   phys_regfile #(
      .XLEN(XLEN), .NUM_PREGS(NUM_PREGS), .NUM_RD(NUM_RD),
      .NUM_WR(NUM_WR), .NUM_ALLOC(NUM_ALLOC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
      .rd_idx(rd_idx), .rd_data(rd_data), .rd_ready(rd_ready),
      .alloc_en(alloc_en), .alloc_idx(alloc_idx), .flush(flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] exp_data(input int i);
      logic [PW-1:0] r;
      logic [XLEN-1:0] d;
      r = rd_idx[i];
      if (!rst_n || r == '0) return '0;
      d = m_mem[r];
      for (int j = 0; j < int'(NUM_WR); j++)
         if (wr_en[j] && wr_idx[j] == r) d = wr_data[j];
      return d;
   endfunction

   function automatic logic exp_ready(input int i);
      logic [PW-1:0] r;
      bit a, w;
      r = rd_idx[i];
      a = 0; w = 0;
      if (!rst_n || r == '0) return 1'b1;
      for (int k = 0; k < int'(NUM_ALLOC); k++) if (alloc_en[k] && alloc_idx[k] == r) a = 1;
      for (int j = 0; j < int'(NUM_WR); j++) if (wr_en[j] && wr_idx[j] == r) w = 1;
      if (a) return m_rdy[r];
      return m_rdy[r] | w;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < int'(NUM_PREGS); k++) begin
         m_mem[k] = '0;
         m_rdy[k] = 1;
      end
   endtask

   task automatic model_update();
      bit a, w;
      for (int j = 0; j < int'(NUM_WR); j++)
         if (wr_en[j] && wr_idx[j] != '0) m_mem[wr_idx[j]] = wr_data[j];
      for (int k = 1; k < int'(NUM_PREGS); k++) begin
         a = 0; w = 0;
         for (int p = 0; p < int'(NUM_ALLOC); p++) if (alloc_en[p] && int'(alloc_idx[p]) == k) a = 1;
         for (int j = 0; j < int'(NUM_WR); j++) if (wr_en[j] && int'(wr_idx[j]) == k) w = 1;
         if (flush)  m_rdy[k] = 1;
         else if (a) m_rdy[k] = 0;
         else if (w) m_rdy[k] = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      wr_en = '0; wr_idx = '0; wr_data = '0;
      alloc_en = '0; alloc_idx = '0; flush = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      for (int i = 0; i < int'(NUM_RD); i++) begin
         checks++;
         if (rd_data[i] !== '0 || rd_ready[i] !== 1'b1) begin
            errors++;
            $display("FAIL reset_init port %0d got %h/%b want 0/1", i, rd_data[i], rd_ready[i]);
         end
      end
      @(negedge clk); rst_n = 1'b1;
      wr_en = 2'b01; wr_idx[0] = 6'd5; wr_data[0] = 32'hA5A5_0005;
      alloc_en = 1'b1; alloc_idx[0] = 6'd7;
      tick();
      wr_en = 2'b11; wr_idx[0] = 6'd5; wr_data[0] = 32'h1234_5678;
      wr_idx[1] = 6'd12; wr_data[1] = 32'h0BAD_F00D;
      alloc_en = 1'b1; alloc_idx[0] = 6'd5;
      rd_idx[0] = 6'd5; rd_idx[1] = 6'd7; rd_idx[2] = 6'd12; rd_idx[3] = 6'd0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < int'(NUM_RD); i++) begin
         checks++;
         if (rd_data[i] !== '0 || rd_ready[i] !== 1'b1) begin
            errors++;
            $display("FAIL reset_async port %0d got %h/%b want 0/1", i, rd_data[i], rd_ready[i]);
         end
      end
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1; idle();
      tick();
      rd_idx[0] = 6'd5;
      #1;
      checks++;
      if (rd_data[0] !== 32'h0 || rd_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_p5 got %h/%b want 0/1", rd_data[0], rd_ready[0]);
      end
   endtask

   task automatic test_bypass();
      idle();
      wr_en = 2'b01; wr_idx[0] = 6'd7; wr_data[0] = 32'hDEAD_BEEF;
      rd_idx[0] = 6'd7;
      #1;
      checks++;
      if (rd_data[0] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL bypass_same got %h want deadbeef", rd_data[0]);
      end
      tick(); idle(); #1;
      checks++;
      if (rd_data[0] !== 32'hDEAD_BEEF || rd_data[0] !== exp_data(0)) begin
         errors++; $display("FAIL bypass_stored got %h want deadbeef", rd_data[0]);
      end
   endtask

   task automatic test_conflict();
      idle();
      wr_en = 2'b11; wr_idx[0] = 6'd9; wr_data[0] = 32'h11;
      wr_idx[1] = 6'd9; wr_data[1] = 32'h22;
      rd_idx[1] = 6'd9;
      #1;
      checks++;
      if (rd_data[1] !== 32'h22) begin
         errors++; $display("FAIL conflict_bypass got %h want 22", rd_data[1]);
      end
      tick(); idle(); #1;
      checks++;
      if (rd_data[1] !== 32'h22) begin
         errors++; $display("FAIL conflict_stored got %h want 22", rd_data[1]);
      end
   endtask

   task automatic test_ready_lifecycle();
      logic [XLEN-1:0] v;
      idle(); rd_idx[2] = 6'd12;
      alloc_en = 1'b1; alloc_idx[0] = 6'd12;
      tick(); idle(); #1;
      checks++;
      if (rd_ready[2] !== 1'b0) begin
         errors++; $display("FAIL rdy_alloc got %b want 0", rd_ready[2]);
      end
      wr_en = 2'b10; wr_idx[1] = 6'd12; wr_data[1] = 32'hC0DE_0012;
      #1;
      checks++;
      if (rd_ready[2] !== 1'b1) begin
         errors++; $display("FAIL rdy_wakeup got %b want 1", rd_ready[2]);
      end
      tick(); idle(); #1;
      checks++;
      if (rd_ready[2] !== 1'b1) begin
         errors++; $display("FAIL rdy_stored got %b want 1", rd_ready[2]);
      end
      v = $urandom();
      wr_en = 2'b01; wr_idx[0] = 6'd12; wr_data[0] = v;
      alloc_en = 1'b1; alloc_idx[0] = 6'd12;
      tick(); idle(); #1;
      checks++;
      if (rd_ready[2] !== 1'b0 || rd_data[2] !== v) begin
         errors++; $display("FAIL rdy_alloc_wr got %b/%h want 0/%h", rd_ready[2], rd_data[2], v);
      end
   endtask

   task automatic test_p0_guard();
      idle();
      rd_idx = '0;
      wr_en = 2'b01; wr_idx[0] = 6'd0; wr_data[0] = 32'hFFFF_FFFF;
      alloc_en = 1'b1; alloc_idx[0] = 6'd0;
      #1;
      for (int i = 0; i < int'(NUM_RD); i++) begin
         checks++;
         if (rd_data[i] !== '0 || rd_ready[i] !== 1'b1) begin
            errors++; $display("FAIL p0_same port %0d got %h/%b want 0/1", i, rd_data[i], rd_ready[i]);
         end
      end
      tick(); idle(); #1;
      checks++;
      if (rd_data[0] !== '0 || rd_ready[0] !== 1'b1) begin
         errors++; $display("FAIL p0_after got %h/%b want 0/1", rd_data[0], rd_ready[0]);
      end
   endtask

   task automatic test_flush();
      idle();
      for (int p = 3; p <= 5; p++) begin
         alloc_en = 1'b1; alloc_idx[0] = PW'(p);
         tick();
      end
      alloc_en = 1'b1; alloc_idx[0] = 6'd6; flush = 1'b1;
      rd_idx[0] = 6'd3; rd_idx[1] = 6'd4; rd_idx[2] = 6'd5; rd_idx[3] = 6'd6;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rd_ready[i] !== 1'b0) begin
            errors++; $display("FAIL flush_pre port %0d got %b want 0", i, rd_ready[i]);
         end
      end
      tick(); idle(); #1;
      for (int i = 0; i < int'(NUM_RD); i++) begin
         checks++;
         if (rd_ready[i] !== 1'b1) begin
            errors++; $display("FAIL flush_post port %0d got %b want 1", i, rd_ready[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [XLEN-1:0] ed;
      logic            er;
      for (int c = 0; c < 400; c++) begin
         for (int j = 0; j < int'(NUM_WR); j++) begin
            wr_en[j]   = ($urandom_range(0, 1) == 1);
            wr_idx[j]  = PW'($urandom_range(0, 15));
            wr_data[j] = $urandom();
         end
         alloc_en[0]  = ($urandom_range(0, 9) < 3);
         alloc_idx[0] = PW'($urandom_range(0, 15));
         flush        = ($urandom_range(0, 29) == 0);
         for (int i = 0; i < int'(NUM_RD); i++) rd_idx[i] = PW'($urandom_range(0, 15));
         #1;
         for (int i = 0; i < int'(NUM_RD); i++) begin
            ed = exp_data(i);
            er = exp_ready(i);
            checks++;
            if (rd_data[i] !== ed || rd_ready[i] !== er) begin
               errors++;
               $display("FAIL rand c%0d port %0d idx %0d got %h/%b want %h/%b",
                        c, i, rd_idx[i], rd_data[i], rd_ready[i], ed, er);
            end
         end
         tick();
      end
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      rd_idx = '0;
      idle();
      model_reset();
      test_reset();
      test_bypass();
      test_conflict();
      test_ready_lifecycle();
      test_p0_guard();
      test_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/phys_regfile.md
PHYS_REGFILE -- requirements
Module: phys_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NUM_PREGS, default 64, physical register count (power of two, >= 2).
REQ-003 SHALL have parameter NUM_RD, default 4, read port count.
REQ-004 SHALL have parameter NUM_WR, default 2, write-back port count.
REQ-005 SHALL have parameter NUM_ALLOC, default 1, allocate (ready-clear) port count.
REQ-006 SHALL have localparam PW = $clog2(NUM_PREGS), the physical register index width.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous and active-low.
REQ-009 wr_en  input  NUM_WR  per-port write enable.
REQ-010 wr_idx  input  NUM_WR x PW  per-port destination physical register.
REQ-011 wr_data  input  NUM_WR x XLEN  per-port write data.
REQ-012 rd_idx  input  NUM_RD x PW  per-port source physical register.
REQ-013 rd_data  output  NUM_RD x XLEN  per-port read data.
REQ-014 rd_ready  output  NUM_RD  per-port source-ready flag.
REQ-015 alloc_en  input  NUM_ALLOC  per-port allocate enable (clears ready).
REQ-016 alloc_idx  input  NUM_ALLOC x PW  per-port allocated physical register.
REQ-017 flush  input  1  synchronous mispredict recovery; sets every ready bit to 1.

Function
REQ-018 Storage SHALL be NUM_PREGS x XLEN data entries plus one ready bit per entry.
REQ-019 Physical register 0 SHALL read as data 0 and ready 1 at all times; writes and allocates to index 0 SHALL be ignored.
REQ-020 Reads SHALL be combinational (zero latency): rd_data[i] = entry rd_idx[i], except as modified by REQ-021 and REQ-019.
REQ-021 If any wr_en[j] is high with wr_idx[j] == rd_idx[i] != 0, rd_data[i] SHALL be wr_data[j] in the same cycle (write-through bypass).
REQ-022 Writes SHALL update the entry on the next rising edge of clk.
REQ-023 When two write ports target the same index in one cycle, the highest-numbered port SHALL win for both storage and bypass.
REQ-024 A write to index k SHALL set ready[k] to 1 on the next edge.
REQ-025 An allocate to index k SHALL clear ready[k] to 0 on the next edge.
REQ-026 Same-cycle allocate and write to the same index SHALL leave ready[k] = 0 (allocate wins; the write data is still stored).
REQ-027 rd_ready[i] SHALL be 1 if ready[rd_idx[i]] is 1 or any same-cycle write targets rd_idx[i] (wakeup bypass), unless a same-cycle allocate targets it, in which case it SHALL reflect the stored bit only.
REQ-028 flush SHALL set all ready bits to 1 on the next edge and take priority over allocate and write ready updates; data writes in the flush cycle SHALL still be stored.
REQ-029 Out-of-range conditions cannot occur (PW bits exactly address NUM_PREGS); no error output is required.

Reset
REQ-030 Assertion of rst_n low SHALL immediately clear all data entries to 0 and set all ready bits to 1, independent of clk.
REQ-031 While rst_n is low, rd_data SHALL be all 0 and rd_ready all 1; writes, allocates and flush SHALL be ignored.
REQ-032 Deassertion SHALL take effect at the first rising edge at which rst_n is high; reset mid-operation SHALL discard any pending updates.

Structure
REQ-033 Default parameter values and the PW derivation SHALL live in a shared package prf_pkg, imported by rename, issue and this block.
REQ-034 The ready-bit array with its allocate/write/flush priority logic SHALL be a sub-module prf_ready_table; data storage and bypass SHALL remain in phys_regfile.

Verification
REQ-035 Reset: drop rst_n mid-cycle -> all rd_data read 0 and rd_ready read 1 immediately; after release, reading p5 returns 0.
REQ-036 Bypass: write port 0 p7 = 0xDEADBEEF while rd_idx[0] = p7 -> rd_data[0] = 0xDEADBEEF in the same cycle, and stored value persists next cycle.
REQ-037 Port conflict: wr port 0 p9 = 0x11, port 1 p9 = 0x22 same cycle -> bypass and next-cycle read both give 0x22.
REQ-038 Ready lifecycle: allocate p12 -> rd_ready 0 next cycle; write p12 -> rd_ready 1 that same cycle (wakeup), stored 1 afterwards; allocate and write p12 together -> remains 0.
REQ-039 p0 guard: write p0 = 0xFFFFFFFF and allocate p0 -> rd_data 0, rd_ready 1 before and after.
REQ-040 Flush: allocate p3, p4, p5 over three cycles, then assert flush with allocate p6 -> next cycle p3..p6 all read ready 1.
